// File: rtl/timer_compare_irq_if.sv
// Avalon-MM slave register port for timer_compare_irq.
// The host drives the master side and the compare block drives readdata.
interface timer_compare_irq_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/timer_compare_irq.sv
// Compare/interrupt extension for an upstream timer: raises a sticky MATCH and a level irq
// when count_in hits COMPARE. Define TIMER_CMP_MATCH_CNT_EN to add the MATCH_COUNT register.
module timer_compare_irq (
    input  logic                  clk,
    input  logic                  reset,
    timer_compare_irq_if.slave    bus,
    input  logic [31:0]           count_in,
    input  logic                  count_en,
    output logic                  irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_COMPARE = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_COUNT   = 2'd3;

    state_t      state_q;
    logic [2:0]  ctrl_q;      // {CONTINUOUS, IRQ_EN, ENABLE}
    logic [2:0]  ctrl_d;
    logic [31:0] compare_q;
    logic [31:0] compare_d;
    logic        match_q;
    logic        match_d;
    logic        irq_q;
    logic        irq_d;

    logic        wr_ctrl;
    logic        wr_compare;
    logic        wr_status;
    logic        count_equal;
    logic        match_hit;

    assign wr_ctrl     = bus.write && (bus.address == ADDR_CTRL);
    assign wr_compare  = bus.write && (bus.address == ADDR_COMPARE);
    assign wr_status   = bus.write && (bus.address == ADDR_STATUS);

    // Evaluation uses only registered values, so a same-cycle write takes effect next edge.
    assign count_equal = count_en && (count_in == compare_q);
    assign match_hit   = (state_q == ARMED) && count_equal;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ctrl_d    = ctrl_q;
        compare_d = compare_q;
        match_d   = match_q;

        if (wr_ctrl) begin
            ctrl_d = bus.writedata[2:0];
        end
        if (wr_compare) begin
            compare_d = bus.writedata;
        end
        if (match_hit) begin
            match_d = 1'b1;
        end else if (wr_status && bus.writedata[0]) begin
            match_d = 1'b0;
        end

        irq_d = match_d & ctrl_d[1];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            compare_q <= '0;
            match_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            irq_q     <= irq_d;

            if (!ctrl_q[0]) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE:  state_q <= ARMED;
                    ARMED: begin
                        if (match_hit) begin
                            state_q <= ctrl_q[2] ? HOLD : FIRED;
                        end
                    end
                    FIRED: begin
                        if (wr_ctrl && bus.writedata[0]) begin
                            state_q <= ARMED;
                        end
                    end
                    HOLD: begin
                        // Wait for the value to move away so one stable value matches once.
                        if (!count_equal) begin
                            state_q <= ARMED;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign irq = irq_q;

`ifdef TIMER_CMP_MATCH_CNT_EN
    logic [31:0] match_cnt_q;
    logic        wr_count;

    assign wr_count = bus.write && (bus.address == ADDR_COUNT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            match_cnt_q <= '0;
        end else if (wr_count) begin
            match_cnt_q <= '0;
        end else if (match_hit && (match_cnt_q != 32'hFFFF_FFFF)) begin
            match_cnt_q <= match_cnt_q + 32'd1;
        end
    end
`endif

    always_comb begin
        bus.readdata = '0;
        if (bus.read) begin
            case (bus.address)
                ADDR_CTRL:    bus.readdata = {29'd0, ctrl_q};
                ADDR_COMPARE: bus.readdata = compare_q;
                ADDR_STATUS:  bus.readdata = {31'd0, match_q};
`ifdef TIMER_CMP_MATCH_CNT_EN
                ADDR_COUNT:   bus.readdata = match_cnt_q;
`else
                ADDR_COUNT:   bus.readdata = '0;
`endif
                default:      bus.readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_compare_irq.sv
// Directed bench for timer_compare_irq: register reads push expected values into a
// scoreboard queue; a negedge monitor pops and compares whenever a read is presented.
module tb_timer_compare_irq;

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_CMP  = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_CNT  = 2'd3;

`ifdef TIMER_CMP_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] count_in;
    logic        count_en;
    logic        irq;

    int n_checks;
    int n_errors;
    exp_t sb_q[$];
    exp_t mon_e;

    timer_compare_irq_if bus ();

    timer_compare_irq dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .count_in (count_in),
        .count_en (count_en),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: compare every presented read against the oldest expected entry.
    always @(negedge clk) begin
        if (bus.read) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_read: got 0x%08h expected no read", bus.readdata);
            end else begin
                mon_e = sb_q.pop_front();
                check(mon_e.name, bus.readdata, mon_e.data);
                check({mon_e.name, "_irq"}, {31'd0, irq}, {31'd0, mon_e.irq});
            end
        end else begin
            check("idle_readdata", bus.readdata, 32'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.write     = 1'b1;
        bus.address   = a;
        bus.writedata = d;
        @(posedge clk);
        #1;
        bus.write     = 1'b0;
        bus.address   = 2'd0;
        bus.writedata = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] d, input logic i,
                            input string nm);
        exp_t e;
        e.name = nm;
        e.data = d;
        e.irq  = i;
        sb_q.push_back(e);
        bus.read    = 1'b1;
        bus.address = a;
        @(posedge clk);
        #1;
        bus.read    = 1'b0;
        bus.address = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b0;
        count_in      = 32'd0;
        count_en      = 1'b0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = 2'd0;
        bus.writedata = 32'd0;

        // Reset, with a CTRL write during reset that must be overridden.
        idle(2);
        bus_write(A_CTRL, 32'd7);
        reset = 1'b1;
        bus_read(A_CTRL, 32'd0, 1'b0, "rst_ctrl");
        bus_read(A_CMP,  32'd0, 1'b0, "rst_compare");
        bus_read(A_STAT, 32'd0, 1'b0, "rst_status");
        bus_read(A_CNT,  32'd0, 1'b0, "rst_count");

        // No match before ENABLE even though count_in == COMPARE == 0.
        count_en = 1'b1;
        idle(3);
        bus_read(A_STAT, 32'd0, 1'b0, "pre_enable_status");

        // One-shot sweep: match becomes visible in the cycle after count_in = 5.
        bus_write(A_CTRL, 32'd3);
        bus_write(A_CMP,  32'd5);
        for (int v = 0; v <= 10; v++) begin
            count_in = v;
            bus_read(A_STAT, (v >= 6) ? 32'd1 : 32'd0, (v >= 6), $sformatf("oneshot_v%0d", v));
        end
        bus_read(A_CNT, CNT_ON ? 32'd1 : 32'd0, 1'b1, "oneshot_count");
        bus_write(A_STAT, 32'd1);
        bus_read(A_STAT, 32'd0, 1'b0, "oneshot_w1c");
        count_in = 32'd5;
        idle(1);
        bus_read(A_STAT, 32'd0, 1'b0, "fired_no_rematch");

        // Continuous: held value matches once, then one match per sweep.
        count_in = 32'd0;
        bus_write(A_CNT,  32'hDEAD_BEEF);
        bus_write(A_CTRL, 32'd7);
        bus_write(A_CMP,  32'd3);
        count_in = 32'd3;
        idle(4);
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v <= 3; v++) begin
                count_in = v;
                idle(1);
            end
        end
        count_in = 32'd9;
        bus_read(A_CNT,  CNT_ON ? 32'd3 : 32'd0, 1'b1, "cont_count");
        bus_read(A_STAT, 32'd1, 1'b1, "cont_status");
        bus_read(A_CTRL, 32'd7, 1'b1, "cont_ctrl");

        // Clear and match on the same edge: the match wins.
        count_in = 32'd3;
        bus_write(A_STAT, 32'd1);
        count_in = 32'd0;
        bus_read(A_STAT, 32'd1, 1'b1, "clear_vs_match");

        // Masked interrupt, then unmask with a CTRL write.
        bus_write(A_CTRL, 32'd0);
        bus_write(A_STAT, 32'd1);
        bus_write(A_CMP,  32'd2);
        bus_write(A_CTRL, 32'd1);
        count_in = 32'd2;
        idle(2);
        bus_read(A_STAT, 32'd1, 1'b0, "mask_status");
        bus_write(A_CTRL, 32'd3);
        count_en = 1'b0;
        bus_read(A_STAT, 32'd1, 1'b1, "unmask_irq");
        bus_read(A_CTRL, 32'd3, 1'b1, "unmask_ctrl");

        // Gating: equal value with count_en = 0 does not match; enabling it does.
        bus_write(A_STAT, 32'd1);
        bus_read(A_STAT, 32'd0, 1'b0, "gated_a");
        bus_read(A_STAT, 32'd0, 1'b0, "gated_b");
        count_en = 1'b1;
        idle(1);
        bus_read(A_STAT, 32'd1, 1'b1, "ungated_match");

        // Reset mid-FIRED, overriding a simultaneous CTRL write.
        reset = 1'b0;
        bus_write(A_CTRL, 32'd7);
        reset    = 1'b1;
        count_in = 32'd0;
        bus_read(A_CTRL, 32'd0, 1'b0, "rst2_ctrl");
        bus_read(A_CMP,  32'd0, 1'b0, "rst2_compare");
        bus_read(A_STAT, 32'd0, 1'b0, "rst2_status");
        bus_read(A_CNT,  32'd0, 1'b0, "rst2_count");
        bus_write(A_CTRL, 32'd1);
        bus_read(A_STAT, 32'd0, 1'b0, "rst2_arming");
        bus_read(A_STAT, 32'd0, 1'b0, "rst2_armed");
        bus_read(A_STAT, 32'd1, 1'b0, "rst2_match");

        // COMPARE writes do not affect the evaluation in their own cycle.
        count_in = 32'd8;
        bus_write(A_CTRL, 32'd1);
        bus_write(A_STAT, 32'd1);
        bus_write(A_CMP,  32'd8);
        count_in = 32'd0;
        bus_read(A_STAT, 32'd0, 1'b0, "newcmp_no_match");
        bus_read(A_STAT, 32'd0, 1'b0, "oldcmp_no_match");
        count_in = 32'd8;
        bus_write(A_CMP, 32'd1);
        bus_read(A_STAT, 32'd1, 1'b0, "oldcmp_applies");
        bus_read(A_CMP,  32'd1, 1'b0, "newcmp_value");

        // CTRL upper bits read back as zero.
        bus_write(A_CTRL, 32'hFFFF_FFF8);
        bus_read(A_CTRL, 32'd0, 1'b0, "ctrl_upper_bits");

        idle(2);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer_compare_irq.md
TIMER_COMPARE_IRQ -- requirements
Module: timer_compare_irq

Interface
REQ-001 The block SHALL have these ports, all sampled or driven on the rising edge of clk:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- address  in  2  register select: 0 CTRL, 1 COMPARE, 2 STATUS, 3 MATCH_COUNT
- read  in  1  Avalon-MM read strobe
- write  in  1  Avalon-MM write strobe
- writedata  in  32  write data
- readdata  out  32  read data
- count_in  in  32  COUNTER value from the upstream timer peripheral
- count_en  in  1  upstream CTRL[0]; the upstream counter is running
- irq  out  1  level interrupt to the Nios II
REQ-002 The block SHALL use one clock, clk, and a synchronous, active-low reset, reset.

Function
REQ-003 CTRL register fields SHALL be: bit0 ENABLE, bit1 IRQ_EN, bit2 CONTINUOUS; bits 31:3 SHALL be written as 0 and read as 0.
REQ-004 COMPARE SHALL be a 32-bit register, fully read/write.
REQ-005 STATUS bit0 MATCH SHALL be sticky and write-1-to-clear; bits 31:1 SHALL read as 0.
REQ-006 readdata SHALL be combinational.
- read=1: the selected register.
- read=0: 0.
REQ-007 The FSM SHALL have states IDLE, ARMED, FIRED and HOLD.
REQ-008 IDLE transitions:
- ENABLE=1 -> ARMED.
- From any state, ENABLE=0 -> IDLE on the next edge.
REQ-009 A match SHALL occur in ARMED when count_en=1 and count_in==COMPARE at the clock edge; the match sets MATCH on that same edge.
REQ-010 On a match:
- CONTINUOUS=0: ARMED -> FIRED.
- CONTINUOUS=1: ARMED -> HOLD.
REQ-011 HOLD SHALL return to ARMED on the first edge where count_in!=COMPARE or count_en=0, so that one stable value yields exactly one match.
REQ-012 FIRED SHALL re-arm (-> ARMED) only on a CTRL write with ENABLE=1; otherwise FIRED SHALL stay in FIRED.
REQ-013 irq SHALL be a register loaded every edge with (next MATCH & next IRQ_EN), so irq rises on the same edge that sets MATCH.
REQ-014 When STATUS is W1C-cleared and a new match occurs in the same cycle, the match SHALL win: MATCH stays 1.
REQ-015 A CTRL or COMPARE write in the same cycle as a match evaluation SHALL NOT affect that evaluation; old register values apply and new values take effect from the next edge.
REQ-016 A COMPARE write while in HOLD SHALL NOT force a match; HOLD still waits for inequality against the new COMPARE.
REQ-017 Writes to address 3 SHALL clear MATCH_COUNT regardless of writedata.
REQ-018 The block SHALL be a pure consumer: it SHALL NOT drive count_in or count_en.

Reset
REQ-019 While reset=0 at an edge, the block SHALL set all of the following, overriding any simultaneous bus write:
- CTRL=0, COMPARE=0, MATCH=0, MATCH_COUNT=0, irq=0
- FSM=IDLE
REQ-020 Reset asserted mid-operation, in any state, SHALL return to the REQ-019 values on that edge.
REQ-021 After reset release, the block SHALL detect no match until ENABLE has been written to 1.

Configuration
REQ-022 The macro TIMER_CMP_MATCH_CNT_EN SHALL control the MATCH_COUNT register (address 3).
- Defined: MATCH_COUNT is a 32-bit register that increments on every match and saturates at 32'hFFFFFFFF.
- Not defined: address 3 reads 0, writes to it are ignored, and no counter register is synthesised.

Verification
REQ-023 One-shot: CTRL=3, COMPARE=5, drive count_in 0..10 with count_en=1.
- MATCH and irq rise on the edge where count_in=5.
- FSM goes to FIRED; no further match at count_in 6..10.
- STATUS W1C (write 1) drops irq on the next edge.
REQ-024 Continuous: CTRL=7, COMPARE=3, hold count_in=3 for 4 cycles, then sweep 0..3 twice.
- MATCH_COUNT=3 (macro defined): one match for the held value plus one per sweep.
- Macro undefined: address 3 reads 0.
REQ-025 Simultaneous clear and match: W1C write to STATUS in the same cycle count_in==COMPARE -> MATCH=1 and irq=1 after the edge.
REQ-026 Mask: CTRL=1 (IRQ_EN=0), match at COMPARE=2.
- MATCH=1, irq=0.
- A later CTRL write of 3 raises irq on the next edge.
REQ-027 Reset mid-FIRED: drive reset=0 for 1 cycle -> all registers read 0, irq=0, and no match at count_in==0 with COMPARE=0 until ENABLE is written.
REQ-028 Gating: count_en=0 with count_in==COMPARE in ARMED -> no match; setting count_en=1 with the same value -> match on that edge.
